// File: rtl/draw_scheduler_pkg.sv
// Shared types and defaults for draw_scheduler: FSM states, screen/coordinate defaults, clog2.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package draw_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_X_W      = 8;
    localparam int DEF_Y_W      = 7;
    localparam int DEF_COL_W    = 3;

    // Ceiling log2, never less than 1 so every counter/pointer has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/draw_scheduler_rr_arbiter.sv
// Round-robin pick: first set req bit searching upward from ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the winner is consumed.
// Ports: req (level requests), ptr (search start) -> gnt (one-hot winner), vld (any request).
module rr_arbiter
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]        req,
    input  logic [clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      vld
);

    localparam int PW = clog2(NUM_REQ);

    // Two passes with constant indices: first the bits at or above ptr, then
    // a wrap-around pass. The second pass can only hit bits below ptr because
    // any requesting bit at or above ptr would already have won.
    always_comb begin
        gnt = '0;
        vld = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!vld && req[j] && (PW'(j) >= ptr)) begin
                gnt[j] = 1'b1;
                vld    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!vld && req[j]) begin
                gnt[j] = 1'b1;
                vld    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Shares the VGA framebuffer write port round-robin among NUM_REQ box-fill requesters, one pixel per cycle.
// Latency: grant + first pixel one cycle after req is sampled in IDLE; BOX_W*BOX_H+2 cycles per box.
// Backpressure: none on the VGA side; requesters wait (level req held) until granted.
//
// Ports: clock/reset (sync, active-low); req/req_x/req_y/req_colour packed per requester;
// grant/done one-hot pulses; busy; vga_x/vga_y/vga_colour/vga_plot to the VGA adapter.
// Optional macro DRAW_SCHEDULER_CLEAR_EN adds clear_req/clear_done for a full-screen colour-0 fill.
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BOX_W    = 60,
    parameter int BOX_H    = 60,
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int X_W      = DEF_X_W,
    parameter int Y_W      = DEF_Y_W,
    parameter int COL_W    = DEF_COL_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*X_W-1:0]   req_x,
    input  logic [NUM_REQ*Y_W-1:0]   req_y,
    input  logic [NUM_REQ*COL_W-1:0] req_colour,
`ifdef DRAW_SCHEDULER_CLEAR_EN
    input  logic                     clear_req,
    output logic                     clear_done,
`endif
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [COL_W-1:0]         vga_colour,
    output logic                     vga_plot
);

    localparam int PW = clog2(NUM_REQ);
`ifdef DRAW_SCHEDULER_CLEAR_EN
    // Counters must also span the whole screen for the clear fill.
    localparam int CW = (clog2(SCREEN_W) > clog2(BOX_W)) ? clog2(SCREEN_W) : clog2(BOX_W);
    localparam int RW = (clog2(SCREEN_H) > clog2(BOX_H)) ? clog2(SCREEN_H) : clog2(BOX_H);
`else
    localparam int CW = clog2(BOX_W);
    localparam int RW = clog2(BOX_H);
`endif

    state_t             state_q,  state_d;
    logic [PW-1:0]      ptr_q,    ptr_d;
    logic [PW-1:0]      owner_q,  owner_d;
    logic [X_W-1:0]     base_x_q, base_x_d;
    logic [Y_W-1:0]     base_y_q, base_y_d;
    logic [COL_W-1:0]   colour_q, colour_d;
    logic [CW-1:0]      col_q,    col_d;
    logic [RW-1:0]      row_q,    row_d;
    logic               first_q,  first_d;
`ifdef DRAW_SCHEDULER_CLEAR_EN
    logic               clr_q,    clr_d;
`endif

    logic [NUM_REQ-1:0] arb_gnt;
    logic               arb_vld;
    logic [PW-1:0]      win_idx;
    logic [X_W-1:0]     sel_x;
    logic [Y_W-1:0]     sel_y;
    logic [COL_W-1:0]   sel_colour;
    logic [NUM_REQ-1:0] owner_oh;
    logic [PW-1:0]      ptr_next;
    logic [CW-1:0]      col_last;
    logic [RW-1:0]      row_last;
    logic [X_W:0]       sum_x;
    logic [Y_W:0]       sum_y;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .vld (arb_vld)
    );

    // Winner index and its operand slices, selected with constant indices.
    always_comb begin
        win_idx    = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                win_idx    = PW'(i);
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_colour = req_colour[i*COL_W +: COL_W];
            end
        end
    end

    always_comb begin
        owner_oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_oh[i] = (owner_q == PW'(i));
        end
    end

    assign ptr_next = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);

`ifdef DRAW_SCHEDULER_CLEAR_EN
    assign col_last = clr_q ? CW'(SCREEN_W - 1) : CW'(BOX_W - 1);
    assign row_last = clr_q ? RW'(SCREEN_H - 1) : RW'(BOX_H - 1);
`else
    assign col_last = CW'(BOX_W - 1);
    assign row_last = RW'(BOX_H - 1);
`endif

    // One bit wider than the ports so a box hanging off the right/bottom edge
    // is recognised as off-screen instead of wrapping back onto it.
    assign sum_x = {1'b0, base_x_q} + (X_W+1)'(col_q);
    assign sum_y = {1'b0, base_y_q} + (Y_W+1)'(row_q);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        base_x_d   = base_x_q;
        base_y_d   = base_y_q;
        colour_d   = colour_q;
        col_d      = col_q;
        row_d      = row_q;
        first_d    = 1'b0;
`ifdef DRAW_SCHEDULER_CLEAR_EN
        clr_d      = clr_q;
        clear_done = 1'b0;
`endif
        grant      = '0;
        done       = '0;
        busy       = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;

        case (state_q)
            IDLE: begin
                col_d = '0;
                row_d = '0;
`ifdef DRAW_SCHEDULER_CLEAR_EN
                clr_d = 1'b0;
                if (clear_req) begin
                    // Full-screen fill from the origin in colour 0; owner untouched.
                    state_d  = DRAW;
                    clr_d    = 1'b1;
                    first_d  = 1'b1;
                    base_x_d = '0;
                    base_y_d = '0;
                    colour_d = '0;
                end else if (arb_vld) begin
`else
                if (arb_vld) begin
`endif
                    state_d  = DRAW;
                    first_d  = 1'b1;
                    owner_d  = win_idx;
                    base_x_d = sel_x;
                    base_y_d = sel_y;
                    colour_d = sel_colour;
                end
            end

            DRAW: begin
                busy       = 1'b1;
                vga_x      = sum_x[X_W-1:0];
                vga_y      = sum_y[Y_W-1:0];
                vga_colour = colour_q;
                vga_plot   = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
`ifdef DRAW_SCHEDULER_CLEAR_EN
                if (first_q && !clr_q) begin
                    grant = owner_oh;
                end
`else
                if (first_q) begin
                    grant = owner_oh;
                end
`endif
                if (col_q == col_last) begin
                    col_d = '0;
                    if (row_q == row_last) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end else begin
                    col_d = col_q + CW'(1);
                end
            end

            DONE: begin
                busy    = 1'b1;
                state_d = IDLE;
`ifdef DRAW_SCHEDULER_CLEAR_EN
                if (clr_q) begin
                    clear_done = 1'b1;
                end else begin
                    done  = owner_oh;
                    ptr_d = ptr_next;
                end
`else
                done  = owner_oh;
                ptr_d = ptr_next;
`endif
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            base_x_q <= '0;
            base_y_q <= '0;
            colour_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
            first_q  <= 1'b0;
`ifdef DRAW_SCHEDULER_CLEAR_EN
            clr_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            base_x_q <= base_x_d;
            base_y_q <= base_y_d;
            colour_q <= colour_d;
            col_q    <= col_d;
            row_q    <= row_d;
            first_q  <= first_d;
`ifdef DRAW_SCHEDULER_CLEAR_EN
            clr_q    <= clr_d;
`endif
        end
    end

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler with a 4x2 box and four requesters.
// Latency: n/a.
// Backpressure: n/a.
module tb_draw_scheduler;

    localparam int NR    = 4;
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int COL_W = 3;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NR-1:0]         req = '0;
    logic [NR*X_W-1:0]     req_x;
    logic [NR*Y_W-1:0]     req_y;
    logic [NR*COL_W-1:0]   req_colour;
    logic [NR-1:0]         grant;
    logic [NR-1:0]         done;
    logic                  busy;
    logic [X_W-1:0]        vga_x;
    logic [Y_W-1:0]        vga_y;
    logic [COL_W-1:0]      vga_colour;
    logic                  vga_plot;
`ifdef DRAW_SCHEDULER_CLEAR_EN
    logic                  clear_req = 1'b0;
    logic                  clear_done;
`endif

    draw_scheduler #(
        .NUM_REQ (NR),
        .BOX_W   (4),
        .BOX_H   (2)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
`ifdef DRAW_SCHEDULER_CLEAR_EN
        .clear_req  (clear_req),
        .clear_done (clear_done),
`endif
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] req;
        logic [3:0] g;
        logic [3:0] d;
        logic       b;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
    } vec_t;

    vec_t tbl[21];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    function automatic vec_t idle_v(input logic [3:0] r);
        vec_t v;
        v = '{req: r, g: 4'd0, d: 4'd0, b: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0, p: 1'b0};
        return v;
    endfunction

    function automatic vec_t px_v(input logic [3:0] g, input logic [7:0] x, input logic [6:0] y,
                                  input logic [2:0] c, input logic p);
        vec_t v;
        v = '{req: 4'd0, g: g, d: 4'd0, b: 1'b1, x: x, y: y, c: c, p: p};
        return v;
    endfunction

    function automatic vec_t dn_v(input logic [3:0] d);
        vec_t v;
        v = '{req: 4'd0, g: 4'd0, d: d, b: 1'b1, x: 8'd0, y: 7'd0, c: 3'd0, p: 1'b0};
        return v;
    endfunction

    function automatic logic [31:0] pack_exp(input vec_t v);
        return {4'd0, v.g, v.d, v.b, v.x, v.y, v.c, v.p};
    endfunction

    function automatic logic [31:0] outs();
        return {4'd0, grant, done, busy, vga_x, vga_y, vga_colour, vga_plot};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 30) begin
            step();
            k++;
        end
        chk(nm, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_g[5];
        logic [3:0] gv[5];
        int         gc[5];
        int         ng;
        int         t0;

        req_x      = {8'd70, 8'd158, 8'd40, 8'd10};
        req_y      = {7'd50, 7'd119, 7'd30, 7'd20};
        req_colour = {3'd1, 3'd5, 3'd6, 3'd3};
        exp_g      = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Table: requester 0 at (10,20) colour 3, then requester 2 clipped at (158,119) colour 5.
        tbl[0]  = idle_v(4'b0001);
        tbl[1]  = px_v(4'b0001, 8'd10, 7'd20, 3'd3, 1'b1);
        tbl[2]  = px_v(4'b0000, 8'd11, 7'd20, 3'd3, 1'b1);
        tbl[3]  = px_v(4'b0000, 8'd12, 7'd20, 3'd3, 1'b1);
        tbl[4]  = px_v(4'b0000, 8'd13, 7'd20, 3'd3, 1'b1);
        tbl[5]  = px_v(4'b0000, 8'd10, 7'd21, 3'd3, 1'b1);
        tbl[6]  = px_v(4'b0000, 8'd11, 7'd21, 3'd3, 1'b1);
        tbl[7]  = px_v(4'b0000, 8'd12, 7'd21, 3'd3, 1'b1);
        tbl[8]  = px_v(4'b0000, 8'd13, 7'd21, 3'd3, 1'b1);
        tbl[9]  = dn_v(4'b0001);
        tbl[10] = idle_v(4'b0100);
        tbl[11] = px_v(4'b0100, 8'd158, 7'd119, 3'd5, 1'b1);
        tbl[12] = px_v(4'b0000, 8'd159, 7'd119, 3'd5, 1'b1);
        tbl[13] = px_v(4'b0000, 8'd160, 7'd119, 3'd5, 1'b0);
        tbl[14] = px_v(4'b0000, 8'd161, 7'd119, 3'd5, 1'b0);
        tbl[15] = px_v(4'b0000, 8'd158, 7'd120, 3'd5, 1'b0);
        tbl[16] = px_v(4'b0000, 8'd159, 7'd120, 3'd5, 1'b0);
        tbl[17] = px_v(4'b0000, 8'd160, 7'd120, 3'd5, 1'b0);
        tbl[18] = px_v(4'b0000, 8'd161, 7'd120, 3'd5, 1'b0);
        tbl[19] = dn_v(4'b0100);
        tbl[20] = idle_v(4'b0000);

        // Reset state
        step();
        step();
        chk("reset_outs", outs(), 32'd0);
        reset = 1'b1;
        step();

        // All four held high from pointer 0: grants 0,1,2,3,0 every 10 cycles.
        req = 4'b1111;
        t0  = cyc;
        ng  = 0;
        for (int k = 0; k < 60 && ng < 5; k++) begin
            step();
            if (grant != 4'd0) begin
                gv[ng] = grant;
                gc[ng] = cyc - t0;
                ng++;
            end
        end
        req = 4'b0000;
        chk("hold_ngrants", 32'(ng), 32'd5);
        for (int i = 0; i < ng; i++) begin
            chk($sformatf("hold_grant%0d", i), {28'd0, gv[i]}, {28'd0, exp_g[i]});
            chk($sformatf("hold_cycle%0d", i), 32'(gc[i]), 32'(1 + 10 * i));
        end
        wait_idle("hold_idle");

        // Table-driven single boxes, including the screen-edge clip.
        for (int i = 0; i < 21; i++) begin
            req = tbl[i].req;
            chk($sformatf("vec%0d", i), outs(), pack_exp(tbl[i]));
            step();
        end

        // Operand and request changes mid-draw must not disturb the box in progress.
        req = 4'b0001;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                chk("mid_grant0", {28'd0, grant}, 32'h1);
                req = 4'b0000;
            end
            if (i == 2) begin
                req             = 4'b0010;
                req_x[7:0]      = 8'd99;
                req_y[6:0]      = 7'd5;
                req_colour[2:0] = 3'd7;
            end
            chk($sformatf("mid_px%0d", i), {13'd0, vga_x, vga_y, vga_colour, vga_plot},
                {13'd0, 8'(10 + i % 4), 7'(20 + i / 4), 3'd3, 1'b1});
            step();
        end
        chk("mid_done0", {28'd0, done}, 32'h1);
        step();
        chk("mid_idle_gap", {27'd0, grant, busy}, 32'd0);
        step();
        chk("mid_grant1", {28'd0, grant}, 32'h2);
        chk("mid_grant1_x", {24'd0, vga_x}, 32'd40);
        req = 4'b0000;
        wait_idle("mid_idle");

        // Reset in the 4th DRAW cycle: immediate IDLE, no done, pointer back to 0.
        req = 4'b0010;
        step();
        chk("rst_grant", {28'd0, grant}, 32'h2);
        req = 4'b0000;
        step();
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        req   = 4'b0101;
        chk("rst_outs", outs(), 32'd0);
        step();
        chk("rst_regrant", {28'd0, grant}, 32'h1);
        req = 4'b0000;
        wait_idle("rst_idle");

`ifdef DRAW_SCHEDULER_CLEAR_EN
        begin
            int np;
            int badc;
            int sawg;
            int sawd;
            int seen;
            np   = 0;
            badc = 0;
            sawg = 0;
            sawd = 0;
            seen = 0;
            clear_req = 1'b1;
            req       = 4'b0001;
            step();
            clear_req = 1'b0;
            for (int k = 0; k < 20000 && seen == 0; k++) begin
                if (vga_plot) begin
                    np++;
                    if (vga_colour != 3'd0) badc++;
                end
                if (grant != 4'd0) sawg++;
                if (clear_done) begin
                    seen = 1;
                    if (done != 4'd0) sawd++;
                end else begin
                    step();
                end
            end
            chk("clr_seen", 32'(seen), 32'd1);
            chk("clr_plots", 32'(np), 32'd19200);
            chk("clr_colour", 32'(badc), 32'd0);
            chk("clr_nogrant", 32'(sawg), 32'd0);
            chk("clr_nodone", 32'(sawd), 32'd0);
            step();
            step();
            chk("clr_then_grant", {28'd0, grant}, 32'h1);
            req = 4'b0000;
            wait_idle("clr_idle");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
